// File: rtl/merge_fifo_reader.sv
// merge_fifo_reader: pop-side controller of one merge-sort level.
// Drains two sorted runs of run_len words from FIFOs A and B and pushes one
// ascending run of 2*run_len words into the output FIFO, one word per cycle.
// Handshake outputs are a Mealy decode so pop and push share the same cycle.
module merge_fifo_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic             a_empty,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_pop_req_n,
  input  logic             b_empty,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_pop_req_n,
  input  logic             o_full,
  output logic             o_push_req_n,
  output logic [WIDTH-1:0] o_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MERGE   = 3'd1,
    ST_DRAIN_A = 3'd2,
    ST_DRAIN_B = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_a_q, cnt_a_d;
  logic [LEN_W-1:0] cnt_b_q, cnt_b_d;
  logic             fire_c;
  logic             sel_a_c;

  // State and remaining-word counters; reset abandons any run in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  // Transfer qualifier and source select; ties go to A to keep the merge stable
  always_comb begin
    fire_c  = 1'b0;
    sel_a_c = 1'b0;
    case (state_q)
      ST_MERGE: begin
        fire_c  = !a_empty && !b_empty && !o_full;
        sel_a_c = (a_data <= b_data);
      end
      ST_DRAIN_A: begin
        fire_c  = !a_empty && !o_full;
        sel_a_c = 1'b1;
      end
      ST_DRAIN_B: begin
        fire_c  = !b_empty && !o_full;
        sel_a_c = 1'b0;
      end
      default: begin
        fire_c  = 1'b0;
        sel_a_c = 1'b0;
      end
    endcase
  end

  // Next state and counter updates; a stalled cycle holds everything
  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (run_len != '0) begin
            state_d = ST_MERGE;
            cnt_a_d = run_len;
            cnt_b_d = run_len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MERGE: begin
        if (fire_c) begin
          if (sel_a_c) begin
            cnt_a_d = cnt_a_q - LEN_W'(1);
            if (cnt_a_q == LEN_W'(1)) begin
              state_d = (cnt_b_q != '0) ? ST_DRAIN_B : ST_DONE;
            end
          end else begin
            cnt_b_d = cnt_b_q - LEN_W'(1);
            if (cnt_b_q == LEN_W'(1)) begin
              state_d = (cnt_a_q != '0) ? ST_DRAIN_A : ST_DONE;
            end
          end
        end
      end
      ST_DRAIN_A: begin
        if (fire_c) begin
          cnt_a_d = cnt_a_q - LEN_W'(1);
          if (cnt_a_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN_B: begin
        if (fire_c) begin
          cnt_b_d = cnt_b_q - LEN_W'(1);
          if (cnt_b_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and status decode; data bus is zero whenever nothing moves
  always_comb begin
    a_pop_req_n  = 1'b1;
    b_pop_req_n  = 1'b1;
    o_push_req_n = 1'b1;
    o_data       = '0;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    if (fire_c) begin
      o_push_req_n = 1'b0;
      if (sel_a_c) begin
        a_pop_req_n = 1'b0;
        o_data      = a_data;
      end else begin
        b_pop_req_n = 1'b0;
        o_data      = b_data;
      end
    end
  end

endmodule

// File: tb/tb_merge_fifo_reader.sv
// Bench for merge_fifo_reader: queue-based FIFO environment plus a reference
// that predicts the merged stream as a stable sort of the two runs.
module tb_merge_fifo_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] run_len;
  logic             a_empty;
  logic [WIDTH-1:0] a_data;
  logic             a_pop_req_n;
  logic             b_empty;
  logic [WIDTH-1:0] b_data;
  logic             b_pop_req_n;
  logic             o_full;
  logic             o_push_req_n;
  logic [WIDTH-1:0] o_data;
  logic             busy;
  logic             done;

  merge_fifo_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .run_len      (run_len),
    .a_empty      (a_empty),
    .a_data       (a_data),
    .a_pop_req_n  (a_pop_req_n),
    .b_empty      (b_empty),
    .b_data       (b_data),
    .b_pop_req_n  (b_pop_req_n),
    .o_full       (o_full),
    .o_push_req_n (o_push_req_n),
    .o_data       (o_data),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] v;
    logic             src_a;
  } ent_t;

  typedef enum int {P_IDLE, P_RUN, P_DONE} phase_e;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] got[$];
  logic             pop_log[$];
  ent_t             exp_q[$];
  logic             a_stall, b_stall, o_stall;
  int               n_checks, n_pass;
  phase_e           ph;
  int               rem_a, rem_b, idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Stable insert: equal values land after those already present
  function automatic void ins(input logic [WIDTH-1:0] v, input logic sa);
    int   p;
    ent_t e;
    p = exp_q.size();
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].v > v) begin
        p = j;
        break;
      end
    end
    e.v     = v;
    e.src_a = sa;
    exp_q.insert(p, e);
  endfunction

  // Expected stream = stable sort of (first n of A) followed by (first n of B)
  function automatic void build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) ins(qa[i], 1'b1);
    for (int i = 0; i < n; i++) ins(qb[i], 1'b0);
  endfunction

  function automatic void fill(input bit to_a, input int n, input int maxv);
    logic [WIDTH-1:0] t[$];
    for (int i = 0; i < n; i++) t.push_back(WIDTH'($urandom_range(0, maxv)));
    t.sort();
    for (int i = 0; i < n; i++) begin
      if (to_a) qa.push_back(t[i]);
      else      qb.push_back(t[i]);
    end
  endfunction

  task automatic drive_flags();
    a_empty = a_stall || (qa.size() == 0);
    a_data  = (qa.size() != 0) ? qa[0] : WIDTH'($urandom);
    b_empty = b_stall || (qb.size() == 0);
    b_data  = (qb.size() != 0) ? qb[0] : WIDTH'($urandom);
    o_full  = o_stall;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive_flags();
  endtask

  task automatic clear_env();
    qa.delete();
    qb.delete();
    got.delete();
    pop_log.delete();
  endtask

  // mode 0: no stalls, 1: scripted stalls, 2: random stalls
  task automatic run_merge(input int n, input int mode, input bit noise, output int dc);
    dc      = -1;
    run_len = LEN_W'(n);
    start   = 1'b1;
    drive_flags();
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 4000; i++) begin
      case (mode)
        1: begin
          o_stall = (i >= 2 && i <= 4);
          a_stall = (i == 7 || i == 8);
        end
        2: begin
          o_stall = ($urandom_range(0, 3) == 0);
          a_stall = ($urandom_range(0, 4) == 0);
          b_stall = ($urandom_range(0, 4) == 0);
        end
        default: ;
      endcase
      if (noise) begin
        start   = ($urandom_range(0, 3) == 0);
        run_len = LEN_W'($urandom);
      end
      drive_flags();
      @(negedge clk);
      if (done === 1'b1) begin
        dc = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    a_stall = 1'b0;
    b_stall = 1'b0;
    o_stall = 1'b0;
    @(posedge clk);
    #1;
    drive_flags();
    n_checks++;
    if (dc > 0) n_pass++;
    else $display("FAIL run_timeout: done not seen, required within 4000 cycles (run_len %0d)", n);
  endtask

  // Compare pushed words against up to 8 packed expected bytes, MSB first
  task automatic chk_seq(input string name, input int n, input logic [63:0] pk);
    chk({name, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) chk(name, 32'(got[i]), 32'(pk[63-8*i -: 8]));
    end
  endtask

  // Per-cycle compare against the reference, plus the FIFO environment
  always @(negedge clk) begin : cmp
    logic             exp_fire, exp_pa, exp_pb;
    logic [WIDTH-1:0] exp_d;
    logic [WIDTH-1:0] tmp;
    ent_t             e;
    exp_fire = 1'b0;
    exp_pa   = 1'b0;
    exp_pb   = 1'b0;
    exp_d    = '0;
    e        = '0;
    if (!rst_n) ph = P_IDLE;
    if (ph == P_RUN && !o_full && (rem_a + rem_b > 0) &&
        (rem_a == 0 || !a_empty) && (rem_b == 0 || !b_empty)) begin
      exp_fire = 1'b1;
      e        = exp_q[idx];
      exp_d    = e.v;
      exp_pa   = e.src_a;
      exp_pb   = !e.src_a;
    end
    chk("busy", 32'(busy), 32'(ph != P_IDLE));
    chk("done", 32'(done), 32'(ph == P_DONE));
    chk("a_pop_req_n", 32'(a_pop_req_n), 32'(!exp_pa));
    chk("b_pop_req_n", 32'(b_pop_req_n), 32'(!exp_pb));
    chk("o_push_req_n", 32'(o_push_req_n), 32'(!exp_fire));
    chk("o_data", 32'(o_data), 32'(exp_d));
    chk("pop_when_empty", 32'((!a_pop_req_n && a_empty) || (!b_pop_req_n && b_empty)), 32'(0));
    chk("push_when_full", 32'(!o_push_req_n && o_full), 32'(0));
    if (!a_pop_req_n && qa.size() > 0) begin
      tmp = qa.pop_front();
      pop_log.push_back(1'b1);
    end
    if (!b_pop_req_n && qb.size() > 0) begin
      tmp = qb.pop_front();
      pop_log.push_back(1'b0);
    end
    if (!o_push_req_n) got.push_back(o_data);
    if (rst_n) begin
      case (ph)
        P_IDLE: begin
          if (start) begin
            idx   = 0;
            rem_a = int'(run_len);
            rem_b = int'(run_len);
            ph    = (run_len == '0) ? P_DONE : P_RUN;
          end
        end
        P_RUN: begin
          if (exp_fire) begin
            idx++;
            if (e.src_a) rem_a--;
            else         rem_b--;
            if (rem_a + rem_b == 0) ph = P_DONE;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  initial begin
    int dc;
    int pa, pb, viol, xa, xb, n;
    logic [5:0] order;
    n_checks = 0;
    n_pass   = 0;
    ph       = P_IDLE;
    rem_a    = 0;
    rem_b    = 0;
    idx      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    run_len  = '0;
    a_stall  = 1'b0;
    b_stall  = 1'b0;
    o_stall  = 1'b0;
    drive_flags();
    #3;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_push_n", 32'(o_push_req_n), 32'(1));
    chk("reset_pops_n", 32'({a_pop_req_n, b_pop_req_n}), 32'(2'b11));
    chk("reset_o_data", 32'(o_data), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_flags();
    cycle();

    // Basic merge
    clear_env();
    qa = '{8'd1, 8'd4, 8'd6, 8'd9};
    qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    build_exp(4);
    run_merge(4, 0, 1'b0, dc);
    chk("basic_done_cycle", 32'(dc), 32'(9));
    chk_seq("basic_seq", 8, 64'h01_02_03_04_06_07_08_09);

    // Ties take A first
    clear_env();
    qa = '{8'd5, 8'd5, 8'd7};
    qb = '{8'd5, 8'd6, 8'd6};
    build_exp(3);
    run_merge(3, 0, 1'b0, dc);
    chk("ties_done_cycle", 32'(dc), 32'(7));
    chk_seq("ties_seq", 6, 64'h05_05_05_06_06_07_00_00);
    order = '0;
    for (int i = 0; i < 6 && i < pop_log.size(); i++) order[5-i] = pop_log[i];
    chk("ties_pop_order", 32'(order), 32'(6'b110001));

    // Drain path
    clear_env();
    qa = '{8'd1, 8'd2, 8'd3};
    qb = '{8'd10, 8'd11, 8'd12};
    build_exp(3);
    run_merge(3, 0, 1'b0, dc);
    chk("drain_done_cycle", 32'(dc), 32'(7));
    chk_seq("drain_seq", 6, 64'h01_02_03_0a_0b_0c_00_00);

    // Scripted stalls: 3 full cycles and 2 empty cycles add 5 cycles
    clear_env();
    qa = '{8'd1, 8'd4, 8'd6, 8'd9};
    qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    build_exp(4);
    run_merge(4, 1, 1'b0, dc);
    chk("stall_done_cycle", 32'(dc), 32'(14));
    chk_seq("stall_seq", 8, 64'h01_02_03_04_06_07_08_09);

    // Zero-length run
    clear_env();
    qa = '{8'd3};
    qb = '{8'd4};
    build_exp(0);
    run_merge(0, 0, 1'b0, dc);
    chk("zero_done_cycle", 32'(dc), 32'(1));
    chk("zero_no_push", 32'(got.size()), 32'(0));
    chk("zero_no_pop", 32'(qa.size() + qb.size()), 32'(2));

    // A fifth word in A stays behind
    clear_env();
    qa = '{8'd1, 8'd4, 8'd6, 8'd9, 8'd99};
    qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    build_exp(4);
    run_merge(4, 0, 1'b0, dc);
    chk_seq("extra_seq", 8, 64'h01_02_03_04_06_07_08_09);
    chk("extra_left", 32'(qa.size()), 32'(1));
    if (qa.size() == 1) chk("extra_word", 32'(qa[0]), 32'(99));

    // Maximum run length with random stalls and ignored start noise
    clear_env();
    fill(1'b1, 255, 255);
    fill(1'b0, 255, 255);
    build_exp(255);
    run_merge(255, 2, 1'b1, dc);
    chk("max_pushes", 32'(got.size()), 32'(510));
    pa = 0;
    pb = 0;
    foreach (pop_log[i]) begin
      if (pop_log[i]) pa++;
      else            pb++;
    end
    chk("max_pops_a", 32'(pa), 32'(255));
    chk("max_pops_b", 32'(pb), 32'(255));
    viol = 0;
    for (int i = 1; i < got.size(); i++) if (got[i] < got[i-1]) viol++;
    chk("max_order", 32'(viol), 32'(0));

    // Back-to-back random merges with narrow values (many ties) and leftovers
    for (int t = 0; t < 8; t++) begin
      clear_env();
      n  = $urandom_range(1, 20);
      xa = $urandom_range(0, 2);
      xb = $urandom_range(0, 2);
      fill(1'b1, n, 7);
      fill(1'b0, n, 7);
      build_exp(n);
      for (int k = 0; k < xa; k++) qa.push_back(WIDTH'($urandom));
      for (int k = 0; k < xb; k++) qb.push_back(WIDTH'($urandom));
      run_merge(n, 2, (t % 2) == 1, dc);
      chk("rand_pushes", 32'(got.size()), 32'(2 * n));
      chk("rand_left_a", 32'(qa.size()), 32'(xa));
      chk("rand_left_b", 32'(qb.size()), 32'(xb));
    end

    // Asynchronous reset after three pushes, then a clean merge
    clear_env();
    qa = '{8'd1, 8'd4, 8'd6, 8'd9};
    qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    build_exp(4);
    run_len = 4'd4;
    start   = 1'b1;
    drive_flags();
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_flags();
    for (int w = 0; w < 50 && got.size() < 3; w++) cycle();
    chk("rst_pushes_before", 32'(got.size()), 32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_a_pop_n", 32'(a_pop_req_n), 32'(1));
    chk("rst_b_pop_n", 32'(b_pop_req_n), 32'(1));
    chk("rst_push_n", 32'(o_push_req_n), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_o_data", 32'(o_data), 32'(0));
    @(posedge clk);
    #1;
    chk("rst_no_more_push", 32'(got.size()), 32'(3));
    clear_env();
    rst_n = 1'b1;
    drive_flags();
    cycle();
    qa = '{8'd1, 8'd4, 8'd6, 8'd9};
    qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    build_exp(4);
    run_merge(4, 0, 1'b0, dc);
    chk("post_rst_done_cycle", 32'(dc), 32'(9));
    chk_seq("post_rst_seq", 8, 64'h01_02_03_04_06_07_08_09);

    cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/merge_fifo_reader.md
# merge_fifo_reader

Pop-side controller for the merge-sort datapath. It drains two input FIFOs (DW_fifo_s1_sf, active-low requests), each holding one ascending sorted run of `run_len` words. It pushes a single merged ascending run of `2*run_len` words into an output FIFO of the same type. It sits between two per-level run FIFOs and the next level's FIFO, and moves one word per cycle when unstalled.

## Interface
Parameters:
- `WIDTH`, 8, data word width (unsigned compare)
- `LEN_W`, 8, width of `run_len`; maximum run length is 2^LEN_W-1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  begin one merge; sampled only in IDLE
- `run_len`  in  LEN_W  words per input run; captured when `start` is accepted
- `a_empty`  in  1  empty flag of input FIFO A
- `a_data`  in  WIDTH  head word of FIFO A (its `data_out`)
- `a_pop_req_n`  out  1  active-low pop to FIFO A
- `b_empty`  in  1  empty flag of input FIFO B
- `b_data`  in  WIDTH  head word of FIFO B
- `b_pop_req_n`  out  1  active-low pop to FIFO B
- `o_full`  in  1  full flag of output FIFO
- `o_push_req_n`  out  1  active-low push to output FIFO
- `o_data`  out  WIDTH  word pushed to output FIFO
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when the merge completes

## Operation
- **State register:** IDLE, MERGE, DRAIN_A, DRAIN_B, DONE.
- **Counters:** `cnt_a` and `cnt_b` (LEN_W bits) hold the words remaining per run.
- **IDLE:**
  - `start`=1 and `run_len`≠0: load both counters with `run_len`, go to MERGE.
  - `start`=1 and `run_len`=0: go to DONE.
- **MERGE (fire = !a_empty & !b_empty & !o_full):**
  - Select A when `a_data` <= `b_data`, otherwise select B. Ties take A, so the merge is stable.
  - Pop the selected FIFO, push its head, and decrement its counter.
- **Leaving MERGE:**
  - When a fire drives `cnt_a` to 0: go to DRAIN_B if `cnt_b`≠0, else DONE.
  - When a fire drives `cnt_b` to 0: go to DRAIN_A if `cnt_a`≠0, else DONE.
- **DRAIN_A:** fire = !a_empty & !o_full; pop A, push `a_data`, decrement `cnt_a`. Go to DONE when `cnt_a` reaches 0. DRAIN_B is the mirror for B.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE and in every busy state.
- **Output decode (Mealy, combinational from state, counters and flags):**
  - `a_pop_req_n`/`b_pop_req_n` are low only on a fire that selects that FIFO.
  - `o_push_req_n` is low only on a fire.
  - `o_data` equals the selected head on a fire, else 0.
- **Safety invariants:**
  - Never pop an empty FIFO or push into a full FIFO.
  - Never pop both inputs in the same cycle.
  - Never pop more than `run_len` words from either input.
- Words beyond the run in either input FIFO are left untouched.

## Timing
- **Reset:** `rst_n`=0 takes effect immediately, not at a clock edge:
  - state goes to IDLE and both counters clear;
  - `a_pop_req_n`=`b_pop_req_n`=`o_push_req_n`=1, `o_data`=0, `busy`=0, `done`=0.
- **Reset mid-merge:** the run is abandoned with no further pops or pushes. FIFO contents are not restored.
- **Start latency:** `start` sampled at edge k puts the block in MERGE after edge k. The first push can occur in the cycle following edge k.
- **Throughput:** one word per cycle when no stall. An unstalled merge takes 2*`run_len` fire cycles plus 1 DONE cycle.
- **Stalls:** any cycle without fire holds state and counters.
- **Handshake:** the pop and the push for a word occur in the same cycle. FIFO head updates take effect after that edge.
- **Back-to-back merges:** the next `start` is accepted in the cycle after `done`.

## Test plan
- **Basic merge:** `run_len`=4, A={1,4,6,9}, B={2,3,7,8}, `o_full`=0 → pushes 1,2,3,4,6,7,8,9 on 8 consecutive cycles, then `done` for 1 cycle and `busy` drops.
- **Ties:** `run_len`=3, A={5,5,7}, B={5,6,6} → output 5(A),5(A),5(B),6,6,7. Verify pop order A,A,B,B,B,A.
- **Drain path:** `run_len`=3, A={1,2,3}, B={10,11,12} → 3 A-pops in MERGE, DRAIN_B for 3 cycles, output 1,2,3,10,11,12.
- **Stalls:** same as basic but `o_full` high for cycles 2–4 and `a_empty` high for 2 cycles mid-run → no push or pop while stalled; same output sequence; completes 5 cycles later. The bench asserts no pop when empty and no push when full, every cycle.
- **Boundaries:** `run_len`=0 → `done` in the cycle after `start` with no pops or pushes. `run_len`=255 with random sorted runs → 510 ordered pushes and exactly 255 pops per input. A 5th word left in A after a 4-word run remains unpopped.
- **Async reset:** assert `rst_n`=0 between clock edges after 3 pushes → all requests deasserted immediately, `busy`=0. After release, a new `start` runs a full merge correctly.
